// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard control for a 5-stage in-order pipeline.
// Generates forwarding selects, load-use stalls, branch flushes, and
// data-memory wait freezes, plus a sticky memory-timeout flag.
// Optional macro HAZARD_STATS_EN adds saturating event counters
// (lu_cnt, br_cnt, frz_cnt).
//
// Stall/flush outputs are combinational from the registered state and the
// current inputs. A freeze holds every pipeline register and masks the
// load-use and branch responses. The held EX instruction presents those
// hazards again once the freeze ends.
module pipe_hazard_ctrl #(
    parameter int INIT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    input  logic       load_e,
    input  logic       pc_src_e,
    input  logic       mem_req_m,
    input  logic       mem_ready,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_em,
    output logic       flush_d,
    output logic       flush_e,
    output logic [1:0] fwd_a_e,
    output logic [1:0] fwd_b_e,
`ifdef HAZARD_STATS_EN
    output logic [15:0] lu_cnt,
    output logic [15:0] br_cnt,
    output logic [15:0] frz_cnt,
`endif
    output logic       mem_err,
    output logic [1:0] state
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] INIT_LAST = (INIT_CYCLES > 1) ? IW'(INIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_WAIT = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] init_cnt_q, init_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_err_q, mem_err_d;
    logic          load_use;
    logic          freeze;
    logic          normal;

    assign state   = state_q;
    assign mem_err = mem_err_q;

    // Forwarding select: MEM result beats WB result; x0 is never forwarded.
    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (reg_write_m && rd_m != 5'd0 && rd_m == rs1_e)      fwd_a_e = 2'b10;
        else if (reg_write_w && rd_w != 5'd0 && rd_w == rs1_e) fwd_a_e = 2'b01;
        if (reg_write_m && rd_m != 5'd0 && rd_m == rs2_e)      fwd_b_e = 2'b10;
        else if (reg_write_w && rd_w != 5'd0 && rd_w == rs2_e) fwd_b_e = 2'b01;
    end

    assign load_use = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    // Next-state logic and stall/flush outputs for the control FSM.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        freeze     = 1'b0;
        normal     = 1'b0;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_em   = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        case (state_q)
            ST_INIT: begin
                stall_f = 1'b1;
                flush_d = 1'b1;
                flush_e = 1'b1;
                if (init_cnt_q == INIT_LAST) begin
                    init_cnt_d = '0;
                    state_d    = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (mem_req_m && !mem_ready) begin
                    freeze     = 1'b1;
                    wait_cnt_d = WW'(1);
                    if (MEM_TIMEOUT <= 1) begin
                        mem_err_d = 1'b1;
                        state_d   = ST_HALT;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    normal = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!mem_ready) begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_q + 1'b1 == WW'(MEM_TIMEOUT)) begin
                        mem_err_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                end else begin
                    normal     = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_RUN;
                end
            end
            default: begin
                freeze = 1'b1;
            end
        endcase

        if (freeze) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_em = 1'b1;
        end
        if (normal) begin
            if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // FSM state, counters and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] lu_cnt_q, lu_cnt_d;
    logic [15:0] br_cnt_q, br_cnt_d;
    logic [15:0] frz_cnt_q, frz_cnt_d;

    assign lu_cnt  = lu_cnt_q;
    assign br_cnt  = br_cnt_q;
    assign frz_cnt = frz_cnt_q;

    // Saturating event counters for applied load-use stalls, branch flushes and freezes.
    always_comb begin
        lu_cnt_d  = lu_cnt_q;
        br_cnt_d  = br_cnt_q;
        frz_cnt_d = frz_cnt_q;
        if (normal && !pc_src_e && load_use && lu_cnt_q != 16'hFFFF) lu_cnt_d = lu_cnt_q + 16'd1;
        if (normal && pc_src_e && br_cnt_q != 16'hFFFF)              br_cnt_d = br_cnt_q + 16'd1;
        if (freeze && frz_cnt_q != 16'hFFFF)                         frz_cnt_d = frz_cnt_q + 16'd1;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lu_cnt_q  <= '0;
            br_cnt_q  <= '0;
            frz_cnt_q <= '0;
        end else begin
            lu_cnt_q  <= lu_cnt_d;
            br_cnt_q  <= br_cnt_d;
            frz_cnt_q <= frz_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl: a table of single-cycle RUN
// vectors followed by hand-written multi-cycle sequences (init, memory wait,
// timeout/halt, reset from HALT and WAIT).
// Compared word: {stall_f, stall_d, stall_em, flush_d, flush_e,
//                 fwd_a_e[1:0], fwd_b_e[1:0], mem_err, state[1:0]}
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       reg_write_m, reg_write_w, load_e, pc_src_e, mem_req_m, mem_ready;
    logic       stall_f, stall_d, stall_em, flush_d, flush_e, mem_err;
    logic [1:0] fwd_a_e, fwd_b_e, state;
`ifdef HAZARD_STATS_EN
    logic [15:0] lu_cnt, br_cnt, frz_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl #(.INIT_CYCLES(2), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .load_e(load_e), .pc_src_e(pc_src_e), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_em(stall_em),
        .flush_d(flush_d), .flush_e(flush_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
`ifdef HAZARD_STATS_EN
        .lu_cnt(lu_cnt), .br_cnt(br_cnt), .frz_cnt(frz_cnt),
`endif
        .mem_err(mem_err), .state(state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic        rwm, rww, ld, br, mreq, mrdy;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [11:0] ev(input logic sf, input logic sd, input logic se,
                                       input logic fd, input logic fe, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic err, input logic [1:0] st);
        return {sf, sd, se, fd, fe, fa, fb, err, st};
    endfunction

    function automatic vec_t mk(input string nm,
                                input logic [4:0] a_rs1_d, input logic [4:0] a_rs2_d,
                                input logic [4:0] a_rs1_e, input logic [4:0] a_rs2_e,
                                input logic [4:0] a_rd_e, input logic [4:0] a_rd_m,
                                input logic [4:0] a_rd_w, input logic a_rwm, input logic a_rww,
                                input logic a_ld, input logic a_br, input logic a_mreq,
                                input logic a_mrdy, input logic [11:0] a_exp);
        vec_t v;
        v.name = nm;
        v.rs1_d = a_rs1_d; v.rs2_d = a_rs2_d; v.rs1_e = a_rs1_e; v.rs2_e = a_rs2_e;
        v.rd_e = a_rd_e; v.rd_m = a_rd_m; v.rd_w = a_rd_w;
        v.rwm = a_rwm; v.rww = a_rww; v.ld = a_ld; v.br = a_br;
        v.mreq = a_mreq; v.mrdy = a_mrdy; v.exp = a_exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rs1_d = v.rs1_d; rs2_d = v.rs2_d; rs1_e = v.rs1_e; rs2_e = v.rs2_e;
        rd_e = v.rd_e; rd_m = v.rd_m; rd_w = v.rd_w;
        reg_write_m = v.rwm; reg_write_w = v.rww; load_e = v.ld; pc_src_e = v.br;
        mem_req_m = v.mreq; mem_ready = v.mrdy;
    endtask

    task automatic idle();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        reg_write_m = 0; reg_write_w = 0; load_e = 0; pc_src_e = 0;
        mem_req_m = 0; mem_ready = 0;
    endtask

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] act;
        act = {stall_f, stall_d, stall_em, flush_d, flush_e, fwd_a_e, fwd_b_e, mem_err, state};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    initial begin
        idle();
        //                 name          rs1d rs2d rs1e rs2e rde rdm rdw rwm rww ld br mreq mrdy
        vecs[0]  = mk("fwd_a_mem",       0,   0,   5,   0,   0,  5,  5,  1,  1,  0, 0, 0, 0, ev(0,0,0,0,0,2'b10,2'b00,0,2'b01));
        vecs[1]  = mk("fwd_a_wb",        0,   0,   5,   0,   0,  0,  5,  1,  1,  0, 0, 0, 0, ev(0,0,0,0,0,2'b01,2'b00,0,2'b01));
        vecs[2]  = mk("fwd_a_rf",        0,   0,   0,   0,   0,  0,  5,  1,  1,  0, 0, 0, 0, ev(0,0,0,0,0,2'b00,2'b00,0,2'b01));
        vecs[3]  = mk("fwd_b_mem",       0,   0,   3,   5,   0,  5,  5,  1,  1,  0, 0, 0, 0, ev(0,0,0,0,0,2'b00,2'b10,0,2'b01));
        vecs[4]  = mk("fwd_b_wb",        0,   0,   0,   9,   0,  9,  9,  0,  1,  0, 0, 0, 0, ev(0,0,0,0,0,2'b00,2'b01,0,2'b01));
        vecs[5]  = mk("fwd_a_nowr_m",    0,   0,   5,   0,   0,  5,  5,  0,  1,  0, 0, 0, 0, ev(0,0,0,0,0,2'b01,2'b00,0,2'b01));
        vecs[6]  = mk("load_use",        0,   7,   0,   0,   7,  0,  0,  0,  0,  1, 0, 0, 0, ev(1,1,0,0,1,2'b00,2'b00,0,2'b01));
        vecs[7]  = mk("load_use_branch", 0,   7,   0,   0,   7,  0,  0,  0,  0,  1, 1, 0, 0, ev(0,0,0,1,1,2'b00,2'b00,0,2'b01));
        vecs[8]  = mk("load_rd0",        0,   0,   0,   0,   0,  0,  0,  0,  0,  1, 0, 0, 0, ev(0,0,0,0,0,2'b00,2'b00,0,2'b01));
        vecs[9]  = mk("no_load",         7,   0,   0,   0,   7,  0,  0,  0,  0,  0, 0, 0, 0, ev(0,0,0,0,0,2'b00,2'b00,0,2'b01));
        vecs[10] = mk("mem_ready_hit",   0,   0,   0,   0,   0,  0,  0,  0,  0,  0, 0, 1, 1, ev(0,0,0,0,0,2'b00,2'b00,0,2'b01));
        vecs[11] = mk("load_use_rs1",    3,   0,   0,   0,   3,  0,  0,  0,  0,  1, 0, 0, 0, ev(1,1,0,0,1,2'b00,2'b00,0,2'b01));

        // Reset and init window.
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk); check("init_cycle0", ev(1,0,0,1,1,2'b00,2'b00,0,2'b00));
        @(posedge clk);
        @(negedge clk); check("init_cycle1", ev(1,0,0,1,1,2'b00,2'b00,0,2'b00));
        @(posedge clk);
        @(negedge clk); check("run_after_init", ev(0,0,0,0,0,2'b00,2'b00,0,2'b01));

        // Table of single-cycle RUN vectors.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1 drive(vecs[i]);
            @(negedge clk); check(vecs[i].name, vecs[i].exp);
        end

        // Memory wait of 3 cycles; freeze masks a pending branch and load-use.
        @(posedge clk); #1 idle();
        mem_req_m = 1; mem_ready = 0; pc_src_e = 1; load_e = 1; rd_e = 7; rs2_d = 7;
        @(negedge clk); check("frz_run", ev(1,1,1,0,0,2'b00,2'b00,0,2'b01));
        @(posedge clk);
        @(negedge clk); check("frz_wait1", ev(1,1,1,0,0,2'b00,2'b00,0,2'b10));
        @(posedge clk);
        @(negedge clk); check("frz_wait2", ev(1,1,1,0,0,2'b00,2'b00,0,2'b10));
        @(posedge clk); #1 mem_ready = 1;
        @(negedge clk); check("wait_ready_branch", ev(0,0,0,1,1,2'b00,2'b00,0,2'b10));
        @(posedge clk); #1 idle();
        @(negedge clk); check("back_to_run", ev(0,0,0,0,0,2'b00,2'b00,0,2'b01));

        // Timeout: 16 cycles of mem_ready low lead to HALT.
        @(posedge clk); #1 mem_req_m = 1; mem_ready = 0;
        @(negedge clk); check("tmo_run", ev(1,1,1,0,0,2'b00,2'b00,0,2'b01));
        for (int i = 2; i <= 16; i++) begin
            @(posedge clk);
            @(negedge clk); check($sformatf("tmo_wait%0d", i), ev(1,1,1,0,0,2'b00,2'b00,0,2'b10));
        end
        @(posedge clk);
        @(negedge clk); check("halt_entry", ev(1,1,1,0,0,2'b00,2'b00,1,2'b11));
        @(posedge clk); #1 mem_ready = 1; rs1_e = 5; rd_m = 5; reg_write_m = 1; pc_src_e = 1;
        @(negedge clk); check("halt_fwd", ev(1,1,1,0,0,2'b10,2'b00,1,2'b11));
        @(posedge clk);
        @(negedge clk); check("halt_sticky", ev(1,1,1,0,0,2'b10,2'b00,1,2'b11));

        // Reset out of HALT.
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1; idle();
        @(negedge clk); check("reset_from_halt", ev(1,0,0,1,1,2'b00,2'b00,0,2'b00));
        @(posedge clk);
        @(negedge clk); check("reinit_cycle1", ev(1,0,0,1,1,2'b00,2'b00,0,2'b00));
        @(posedge clk);
        @(negedge clk); check("rerun", ev(0,0,0,0,0,2'b00,2'b00,0,2'b01));

        // Reset in the middle of WAIT.
        @(posedge clk); #1 mem_req_m = 1; mem_ready = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); check("pre_reset_wait", ev(1,1,1,0,0,2'b00,2'b00,0,2'b10));
        @(posedge clk); #1 rst = 1'b1; idle();
        @(negedge clk); check("reset_from_wait", ev(1,0,0,1,1,2'b00,2'b00,0,2'b00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
